// File: rtl/io_gpio_bank.sv
// Memory-mapped bank of NUM_PORTS output ports with atomic set/clr/tog and a per-port one-shot pulse engine.
// Latency: register writes take effect on the next clk edge; io_rdata is registered (1 cycle read latency).
// Backpressure: none; every bus access completes in one cycle, and a pulse start while busy is dropped and flagged.
//
// Ports:
//   clk, reset       system clock, asynchronous active-low reset
//   io_sel           IO-space data access strobe
//   io_device        device field; the bank answers only to DEVICE_ID
//   io_address       [7:5] port index, [4:2] register index, [1:0] ignored
//   mem_wdata        write data
//   mem_wmask        byte write mask, all-zero means read
//   io_rdata         registered read data, zero after any non-read cycle
//   port_out         port p at bits [p*PORT_WIDTH +: PORT_WIDTH]
//   pulse_busy       per-port pulse engine active
module io_gpio_bank #(
    parameter int                    NUM_PORTS   = 2,
    parameter int                    PORT_WIDTH  = 8,
    parameter logic [7:0]            DEVICE_ID   = 8'h00,
    parameter int                    PULSE_W     = 24,
    parameter logic [PORT_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            io_sel,
    input  logic [7:0]                      io_device,
    input  logic [7:0]                      io_address,
    input  logic [31:0]                     mem_wdata,
    input  logic [3:0]                      mem_wmask,
    output logic [31:0]                     io_rdata,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] port_out,
    output logic [NUM_PORTS-1:0]            pulse_busy
);

    typedef enum logic {
        P_IDLE   = 1'b0,
        P_ACTIVE = 1'b1
    } pstate_e;

    localparam logic [2:0] R_OUT    = 3'd0;
    localparam logic [2:0] R_SET    = 3'd1;
    localparam logic [2:0] R_CLR    = 3'd2;
    localparam logic [2:0] R_TOG    = 3'd3;
    localparam logic [2:0] R_PMASK  = 3'd4;
    localparam logic [2:0] R_PLEN   = 3'd5;
    localparam logic [2:0] R_STATUS = 3'd6;

    localparam logic [3:0] NP = 4'(NUM_PORTS);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic        hit;
    logic        wr_en;
    logic        rd_en;
    logic [2:0]  port_idx;
    logic [2:0]  reg_idx;
    logic        port_ok;
    logic [31:0] lane;
    logic [31:0] wdata_m;

    assign hit      = io_sel && (io_device == DEVICE_ID);
    assign wr_en    = hit && (mem_wmask != 4'b0000);
    assign rd_en    = hit && (mem_wmask == 4'b0000);
    assign port_idx = io_address[7:5];
    assign reg_idx  = io_address[4:2];
    assign port_ok  = ({1'b0, port_idx} < NP);
    assign lane     = {{8{mem_wmask[3]}}, {8{mem_wmask[2]}},
                       {8{mem_wmask[1]}}, {8{mem_wmask[0]}}};
    // Disabled lanes contribute zeros; OUT/PLEN merge old bits back in below.
    assign wdata_m  = mem_wdata & lane;

    logic unused_ok;
    assign unused_ok = ^{io_address[1:0], mem_wdata};

    // Read value per possible port index; indices beyond NUM_PORTS read 0.
    logic [31:0] rd_val [8];

    // ------------------------------------------------------------------
    // Per-port register file and pulse engine
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        logic [PORT_WIDTH-1:0] out_q, out_d;
        logic [PORT_WIDTH-1:0] mask_q, mask_d;
        logic [PULSE_W-1:0]    plen_q, plen_d;
        logic [PULSE_W-1:0]    cnt_q, cnt_d;
        logic                  ovr_q, ovr_d;
        pstate_e               state_q, state_d;

        logic                  wr_p;
        logic                  rd_p;
        logic [PORT_WIDTH-1:0] wd;
        logic [PORT_WIDTH-1:0] restore;
        logic [PORT_WIDTH-1:0] base;
        logic                  start;
        logic [31:0]           out_merge;
        logic [31:0]           plen_merge;

        assign wr_p = wr_en && (port_idx == 3'(g));
        assign rd_p = rd_en && (port_idx == 3'(g));
        assign wd   = wdata_m[PORT_WIDTH-1:0];

        // Pulse FSM: next state, counter, latched mask, overrun flag.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            mask_d  = mask_q;
            ovr_d   = ovr_q;
            restore = '0;
            start   = 1'b0;
            case (state_q)
                P_IDLE: begin
                    if (wr_p && (reg_idx == R_PMASK) && (wd != '0) && (plen_q != '0)) begin
                        start   = 1'b1;
                        state_d = P_ACTIVE;
                        cnt_d   = plen_q;
                        mask_d  = wd;
                    end
                end
                P_ACTIVE: begin
                    cnt_d = cnt_q - PULSE_W'(1);
                    // Last active edge: undo the inversion and release the engine.
                    if (cnt_q == PULSE_W'(1)) begin
                        restore = mask_q;
                        mask_d  = '0;
                        state_d = P_IDLE;
                    end
                    if (wr_p && (reg_idx == R_PMASK)) begin
                        ovr_d = 1'b1;
                    end
                end
                default: state_d = P_IDLE;
            endcase
            // Read and write cannot coincide, so clear-on-read never races a set.
            if (rd_p && (reg_idx == R_STATUS)) begin
                ovr_d = 1'b0;
            end
        end

        // OUT / PLEN: restore is applied first, then the software operation.
        always_comb begin
            base       = out_q ^ restore;
            out_d      = base;
            plen_d     = plen_q;
            out_merge  = (32'(base) & ~lane) | wdata_m;
            plen_merge = (32'(plen_q) & ~lane) | wdata_m;
            if (wr_p) begin
                case (reg_idx)
                    R_OUT:  out_d  = out_merge[PORT_WIDTH-1:0];
                    R_SET:  out_d  = base | wd;
                    R_CLR:  out_d  = base & ~wd;
                    R_TOG:  out_d  = base ^ wd;
                    R_PLEN: plen_d = plen_merge[PULSE_W-1:0];
                    default: ;
                endcase
            end
            if (start) begin
                out_d = base ^ wd;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                out_q   <= RESET_VALUE;
                mask_q  <= '0;
                plen_q  <= '0;
                cnt_q   <= '0;
                ovr_q   <= 1'b0;
                state_q <= P_IDLE;
            end else begin
                out_q   <= out_d;
                mask_q  <= mask_d;
                plen_q  <= plen_d;
                cnt_q   <= cnt_d;
                ovr_q   <= ovr_d;
                state_q <= state_d;
            end
        end

        assign port_out[g*PORT_WIDTH +: PORT_WIDTH] = out_q;
        assign pulse_busy[g] = (state_q == P_ACTIVE);

        always_comb begin
            rd_val[g] = 32'd0;
            case (reg_idx)
                R_OUT:    rd_val[g] = 32'(out_q);
                R_PMASK:  rd_val[g] = 32'(mask_q);
                R_PLEN:   rd_val[g] = 32'(plen_q);
                R_STATUS: rd_val[g] = {30'd0, ovr_q, (state_q == P_ACTIVE)};
                default:  rd_val[g] = 32'd0;
            endcase
        end
    end

    for (genvar g = NUM_PORTS; g < 8; g++) begin : g_noport
        assign rd_val[g] = 32'd0;
    end

    // ------------------------------------------------------------------
    // Registered read data
    // ------------------------------------------------------------------
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = 32'd0;
        if (rd_en && port_ok) begin
            rdata_d = rd_val[port_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= 32'd0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign io_rdata = rdata_q;

endmodule

// File: tb/tb_io_gpio_bank.sv
module tb_io_gpio_bank;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        io_sel;
    logic [7:0]  io_device;
    logic [7:0]  io_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;

    logic [31:0] rdata0;
    logic [15:0] port_out0;
    logic [1:0]  busy0;
    logic [31:0] rdata1;
    logic [15:0] port_out1;
    logic [0:0]  busy1;

    // Default bank: two 8-bit ports at device 0.
    io_gpio_bank u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .io_sel     (io_sel),
        .io_device  (io_device),
        .io_address (io_address),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .io_rdata   (rdata0),
        .port_out   (port_out0),
        .pulse_busy (busy0)
    );

    // One 16-bit port at device 1 for byte-lane checks.
    io_gpio_bank #(
        .NUM_PORTS  (1),
        .PORT_WIDTH (16),
        .DEVICE_ID  (8'h01)
    ) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .io_sel     (io_sel),
        .io_device  (io_device),
        .io_address (io_address),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .io_rdata   (rdata1),
        .port_out   (port_out1),
        .pulse_busy (busy1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          inst;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic wr(input logic [7:0] dev, input logic [7:0] addr,
                      input logic [31:0] d, input logic [3:0] m);
        io_sel     = 1'b1;
        io_device  = dev;
        io_address = addr;
        mem_wdata  = d;
        mem_wmask  = m;
        @(negedge clk);
        io_sel     = 1'b0;
        mem_wmask  = 4'b0000;
    endtask

    task automatic rd(input logic [7:0] dev, input logic [7:0] addr,
                      input bit inst, input logic [31:0] exp, input string tag);
        sb_t e;
        sb_t got;
        e.inst = inst;
        e.exp  = exp;
        sb_q.push_back(e);
        io_sel     = 1'b1;
        io_device  = dev;
        io_address = addr;
        mem_wdata  = 32'hDEAD_BEEF;
        mem_wmask  = 4'b0000;
        @(negedge clk);
        io_sel     = 1'b0;
        got = sb_q.pop_front();
        check(tag, got.inst ? rdata1 : rdata0, got.exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset      = 1'b0;
        io_sel     = 1'b0;
        io_device  = 8'h00;
        io_address = 8'h00;
        mem_wdata  = 32'h0;
        mem_wmask  = 4'b0000;
        idle(3);
        reset = 1'b1;
        idle(1);

        // Reset state
        check("rst_port_out", 32'(port_out0), 32'h0);
        check("rst_busy", 32'(busy0), 32'h0);
        check("rst_rdata", rdata0, 32'h0);
        rd(8'h00, 8'h00, 0, 32'h00, "rst_rd_out");
        rd(8'h00, 8'h14, 0, 32'h00, "rst_rd_plen");

        // Atomic ops on port 0
        wr(8'h00, 8'h00, 32'h0000_00A5, 4'b0001);
        check("out_a5", 32'(port_out0), 32'h0000_00A5);
        wr(8'h00, 8'h04, 32'h0000_000F, 4'b0001);
        check("set_0f", 32'(port_out0), 32'h0000_00AF);
        wr(8'h00, 8'h08, 32'h0000_0080, 4'b0001);
        check("clr_80", 32'(port_out0), 32'h0000_002F);
        wr(8'h00, 8'h0C, 32'h0000_00FF, 4'b0001);
        check("tog_ff", 32'(port_out0), 32'h0000_00D0);
        rd(8'h00, 8'h00, 0, 32'h0000_00D0, "rd_out_d0");
        idle(1);
        check("rdata_zero_after_idle", rdata0, 32'h0);

        // Port isolation, wrong device, out-of-range port, reserved register
        wr(8'h00, 8'h20, 32'h0000_003C, 4'b1111);
        check("port1_out", 32'(port_out0), 32'h0000_3CD0);
        wr(8'h05, 8'h00, 32'h0000_0011, 4'b0001);
        check("wrong_dev", 32'(port_out0), 32'h0000_3CD0);
        wr(8'h00, 8'h40, 32'h0000_00FF, 4'b0001);
        check("bad_port_wr", 32'(port_out0), 32'h0000_3CD0);
        rd(8'h00, 8'h40, 0, 32'h0, "bad_port_rd");
        rd(8'h00, 8'h3C, 0, 32'h0, "reserved_rd");
        rd(8'h00, 8'h23, 0, 32'h0000_003C, "port1_rd_lowbits_ignored");
        // Disabled lane contributes zero to SET
        wr(8'h00, 8'h04, 32'h0000_00FF, 4'b0010);
        check("set_lane_off", 32'(port_out0), 32'h0000_3CD0);

        // Byte lane masking on the 16-bit instance
        wr(8'h01, 8'h00, 32'h0000_1234, 4'b0011);
        check("w16_1234", 32'(port_out1), 32'h0000_1234);
        wr(8'h01, 8'h00, 32'h0000_FFFF, 4'b0010);
        check("w16_ff34", 32'(port_out1), 32'h0000_FF34);
        rd(8'h01, 8'h00, 1, 32'h0000_FF34, "w16_rd");
        check("w16_dev0_untouched", 32'(port_out0), 32'h0000_3CD0);

        // Pulse: PLEN=3, PMASK=0x01 on OUT=0
        wr(8'h00, 8'h00, 32'h0, 4'b0001);
        wr(8'h00, 8'h14, 32'h3, 4'b1111);
        rd(8'h00, 8'h14, 0, 32'h3, "plen_rd");
        wr(8'h00, 8'h10, 32'h1, 4'b0001);
        check("pulse_c1_out", 32'(port_out0[7:0]), 32'h01);
        check("pulse_c1_busy", 32'(busy0), 32'h1);
        wr(8'h00, 8'h10, 32'h2, 4'b0001);   // dropped, sets overrun
        check("pulse_c2_out", 32'(port_out0[7:0]), 32'h01);
        check("pulse_c2_busy", 32'(busy0), 32'h1);
        rd(8'h00, 8'h18, 0, 32'h3, "status_busy_ovr");
        check("pulse_c3_out", 32'(port_out0[7:0]), 32'h01);
        check("pulse_c3_busy", 32'(busy0), 32'h1);
        idle(1);
        check("pulse_end_out", 32'(port_out0[7:0]), 32'h00);
        check("pulse_end_busy", 32'(busy0), 32'h0);
        rd(8'h00, 8'h18, 0, 32'h0, "status_cleared");
        rd(8'h00, 8'h10, 0, 32'h0, "pmask_rd_idle");

        // Collision: SET on the restore edge wins
        wr(8'h00, 8'h14, 32'h2, 4'b0001);
        wr(8'h00, 8'h10, 32'h1, 4'b0001);
        check("col_start", 32'(port_out0[7:0]), 32'h01);
        idle(1);
        wr(8'h00, 8'h04, 32'h1, 4'b0001);
        check("col_out", 32'(port_out0[7:0]), 32'h01);
        check("col_busy", 32'(busy0), 32'h0);

        // PLEN=0: PMASK ignored
        wr(8'h00, 8'h00, 32'h0, 4'b0001);
        wr(8'h00, 8'h14, 32'h0, 4'b1111);
        wr(8'h00, 8'h10, 32'h1, 4'b0001);
        check("plen0_out", 32'(port_out0[7:0]), 32'h00);
        check("plen0_busy", 32'(busy0), 32'h0);
        idle(1);
        check("plen0_busy2", 32'(busy0), 32'h0);

        // Reset mid-pulse with cnt=5
        wr(8'h00, 8'h34, 32'h4, 4'b0001);   // port 1 PLEN, should also be cleared
        wr(8'h00, 8'h14, 32'h5, 4'b0001);
        wr(8'h00, 8'h10, 32'h1, 4'b0001);
        check("mid_start_busy", 32'(busy0), 32'h1);
        reset = 1'b0;
        #1;
        check("mid_rst_out", 32'(port_out0), 32'h0);
        check("mid_rst_busy", 32'(busy0), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            idle(1);
            check($sformatf("post_rst_out_%0d", i), 32'(port_out0), 32'h0);
            check($sformatf("post_rst_busy_%0d", i), 32'(busy0), 32'h0);
        end
        rd(8'h00, 8'h14, 0, 32'h0, "post_rst_plen");
        rd(8'h00, 8'h34, 0, 32'h0, "post_rst_plen_p1");
        rd(8'h00, 8'h18, 0, 32'h0, "post_rst_status");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
